traffic_ped_ctrl: RTL

Pedestrian-crossing traffic controller that sequences the car and pedestrian lamps and produces the walk-countdown value for the two-digit FND decoder stage. It sits directly upstream of the FND decoder: o_Data/o_Ctrl drive that block's i_Data/i_Ctrl. The FND decoder displays (i_Data − 0x10) when i_Ctrl=1 and blanks otherwise, so this block emits the remaining walk seconds in BCD with the tens digit offset by +1.

---
 rtl/traffic_ped_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/traffic_ped_ctrl.sv
// Pedestrian-crossing controller: sequences car/ped lamps and feeds the walk
// countdown (tens digit offset by +1) to the downstream two-digit FND decoder.
module traffic_ped_ctrl #(
    parameter int P_TICK_DIV   = 50_000_000,
    parameter int P_GREEN_SEC  = 30,
    parameter int P_YELLOW_SEC = 3,
    parameter int P_WALK_SEC   = 20,
    parameter int P_CLEAR_SEC  = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_PedReq,
    output logic [2:0] o_CarLight,
    output logic [1:0] o_PedLight,
    output logic [7:0] o_Data,
    output logic       o_Ctrl
);

    localparam int               LP_TW          = (P_TICK_DIV > 2) ? $clog2(P_TICK_DIV) : 1;
    localparam logic [LP_TW-1:0] LP_TICK_MAX    = LP_TW'(P_TICK_DIV - 1);
    localparam logic [7:0]       LP_GREEN_MIN   = 8'(P_GREEN_SEC);
    localparam logic [7:0]       LP_YELLOW_LAST = 8'(P_YELLOW_SEC - 1);
    localparam logic [7:0]       LP_CLEAR_LAST  = 8'(P_CLEAR_SEC - 1);
    localparam logic [3:0]       LP_WALK_TENS   = 4'(P_WALK_SEC / 10);
    localparam logic [3:0]       LP_WALK_ONES   = 4'(P_WALK_SEC % 10);

    typedef enum logic [1:0] {
        S_GREEN,
        S_YELLOW,
        S_WALK,
        S_CLEAR
    } state_t;

    state_t           r_State;
    state_t           w_Next;
    logic [LP_TW-1:0] r_TickCnt;
    logic [7:0]       r_SecCnt;
    logic [3:0]       r_Tens;
    logic [3:0]       r_Ones;
    logic             r_Prev;
    logic             r_Edge;
    logic             r_Latch;
    logic             w_Tick;
    logic             w_SetLatch;
    logic             w_Change;
    logic             w_Blink;
    logic             w_CountZero;

    assign w_Tick      = (r_TickCnt == LP_TICK_MAX);
    assign w_SetLatch  = r_Edge && (r_State == S_GREEN);
    assign w_Change    = (w_Next != r_State);
    assign w_CountZero = (r_Tens == 4'd0) && (r_Ones == 4'd0);
    assign w_Blink     = (r_Tens == 4'd0) && (r_Ones <= 4'd5) && r_Ones[0];

    // A request latched on the same cycle already counts toward leaving green.
    always_comb begin
        w_Next = r_State;
        case (r_State)
            S_GREEN:  if ((r_SecCnt >= LP_GREEN_MIN) && (r_Latch || w_SetLatch)) w_Next = S_YELLOW;
            S_YELLOW: if (w_Tick && (r_SecCnt == LP_YELLOW_LAST)) w_Next = S_WALK;
            S_WALK:   if (w_Tick && w_CountZero) w_Next = S_CLEAR;
            S_CLEAR:  if (w_Tick && (r_SecCnt == LP_CLEAR_LAST)) w_Next = S_GREEN;
            default:  w_Next = S_GREEN;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State    <= S_GREEN;
            r_TickCnt  <= '0;
            r_SecCnt   <= 8'd0;
            r_Tens     <= 4'd0;
            r_Ones     <= 4'd0;
            r_Prev     <= 1'b0;
            r_Edge     <= 1'b0;
            r_Latch    <= 1'b0;
            o_CarLight <= 3'b001;
            o_PedLight <= 2'b10;
            o_Data     <= 8'h10;
            o_Ctrl     <= 1'b0;
        end else begin
            r_Prev  <= i_PedReq;
            r_Edge  <= i_PedReq & ~r_Prev;
            r_State <= w_Next;

            // State change wins over a coincident tick so each state gets whole seconds.
            if (w_Change) begin
                r_TickCnt <= '0;
                r_SecCnt  <= 8'd0;
            end else begin
                r_TickCnt <= w_Tick ? '0 : r_TickCnt + LP_TW'(1);
                if (w_Tick && (r_SecCnt != 8'hFF)) r_SecCnt <= r_SecCnt + 8'd1;
            end

            if (w_Change && (w_Next == S_WALK)) r_Latch <= 1'b0;
            else if (w_SetLatch)                r_Latch <= 1'b1;

            if (w_Change && (w_Next == S_WALK)) begin
                r_Tens <= LP_WALK_TENS;
                r_Ones <= LP_WALK_ONES;
            end else if ((r_State == S_WALK) && w_Tick && !w_Change) begin
                if (r_Ones == 4'd0) begin
                    r_Ones <= 4'd9;
                    r_Tens <= r_Tens - 4'd1;
                end else begin
                    r_Ones <= r_Ones - 4'd1;
                end
            end

            case (r_State)
                S_GREEN: begin
                    o_CarLight <= 3'b001;
                    o_PedLight <= 2'b10;
                    o_Data     <= 8'h10;
                    o_Ctrl     <= 1'b0;
                end
                S_YELLOW: begin
                    o_CarLight <= 3'b010;
                    o_PedLight <= 2'b10;
                    o_Data     <= 8'h10;
                    o_Ctrl     <= 1'b0;
                end
                S_WALK: begin
                    o_CarLight <= 3'b100;
                    o_PedLight <= {1'b0, ~w_Blink};
                    o_Data     <= {r_Tens + 4'd1, r_Ones};
                    o_Ctrl     <= 1'b1;
                end
                default: begin
                    o_CarLight <= 3'b100;
                    o_PedLight <= 2'b10;
                    o_Data     <= 8'h10;
                    o_Ctrl     <= 1'b0;
                end
            endcase
        end
    end

endmodule
